// File: rtl/paddle_key_ctrl.sv
// PS/2 set-2 key tracker for a two-paddle game: decodes W/S/O/K make/break codes
// into held flags and paddle directions, with a frame-based inactivity timeout.
module paddle_key_ctrl #(
  parameter int TIMEOUT_FRAMES = 120,
  parameter int CNT_W          = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  input  logic       frame_tick,
  output logic [3:0] held,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       move_stb
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t           state, state_nxt;
  logic [3:0]       held_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  function automatic logic [3:0] key_mask(input logic [7:0] b);
    case (b)
      8'h1D:   return 4'b0001;
      8'h1B:   return 4'b0010;
      8'h44:   return 4'b0100;
      8'h42:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] dir_of(input logic up, input logic dn);
    case ({dn, up})
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    cnt_nxt   = cnt;
    if (key_valid) begin
      cnt_nxt = '0;
      case (state)
        IDLE: begin
          if (key_data == 8'hF0)      state_nxt = BRK;
          else if (key_data == 8'hE0) state_nxt = EXT;
          else                        held_nxt  = held | key_mask(key_data);
        end
        BRK: begin
          held_nxt  = held & ~key_mask(key_data);
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (key_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (frame_tick && (cnt != TMO)) begin
      cnt_nxt = cnt + 1'b1;
      // Timeout fires only on the tick that reaches the limit, so keys pressed
      // after a timeout are tracked again normally.
      if (cnt_nxt == TMO) begin
        held_nxt  = '0;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      held     <= '0;
      p1_dir   <= 2'b00;
      p2_dir   <= 2'b00;
      move_stb <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      held     <= held_nxt;
      p1_dir   <= dir_of(held_nxt[0], held_nxt[1]);
      p2_dir   <= dir_of(held_nxt[2], held_nxt[3]);
      move_stb <= frame_tick;
    end
  end

endmodule

// File: tb/tb_paddle_key_ctrl.sv
// Self-checking bench for paddle_key_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a prefix-queue model.
module tb_paddle_key_ctrl;

  localparam int TMO = 120;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       frame_tick = 1'b0;
  logic [3:0] held;
  logic [1:0] p1_dir, p2_dir;
  logic       move_stb;

  int checks = 0;
  int failures = 0;

  paddle_key_ctrl #(.TIMEOUT_FRAMES(TMO), .CNT_W(8)) dut (
    .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
    .frame_tick(frame_tick), .held(held), .p1_dir(p1_dir), .p2_dir(p2_dir),
    .move_stb(move_stb)
  );

  always #5 clock = ~clock;

  // Reference model: pending prefix bytes, held flags, frames since last key.
  logic [3:0] m_held = 4'b0000;
  logic       m_move = 1'b0;
  int         m_idle = 0;
  logic [7:0] pre[$];

  function automatic logic [3:0] mask_of(input logic [7:0] b);
    if (b == 8'h1D) return 4'b0001;
    if (b == 8'h1B) return 4'b0010;
    if (b == 8'h44) return 4'b0100;
    if (b == 8'h42) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] exp_dir(input logic up, input logic dn);
    if (up && !dn) return 2'b01;
    if (dn && !up) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_held = 4'b0000; m_move = 1'b0; m_idle = 0; pre.delete();
      end else begin
        m_move = frame_tick;
        if (key_valid) begin
          m_idle = 0;
          if ((pre.size() == 0 && (key_data == 8'hF0 || key_data == 8'hE0)) ||
              (pre.size() == 1 && pre[0] == 8'hE0 && key_data == 8'hF0)) begin
            pre.push_back(key_data);
          end else begin
            if (pre.size() == 0) m_held = m_held | mask_of(key_data);
            else if (pre.size() == 1 && pre[0] == 8'hF0) m_held = m_held & ~mask_of(key_data);
            pre.delete();
          end
        end else if (frame_tick && m_idle < TMO) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_held = 4'b0000; pre.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("cyc_held", 8'(held), 8'(m_held));
    chk("cyc_p1", 8'(p1_dir), 8'(exp_dir(m_held[0], m_held[1])));
    chk("cyc_p2", 8'(p2_dir), 8'(exp_dir(m_held[2], m_held[3])));
    chk("cyc_move", 8'(move_stb), 8'(m_move));
  end

  // Inputs change 1 time unit after the falling edge, clear of both edges.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic t);
    key_valid = 1'b1; key_data = b; frame_tick = t;
    step();
    key_valid = 1'b0; frame_tick = 1'b0; key_data = 8'h5A;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic lit(input string name, input logic [3:0] h, input logic [1:0] p1,
                     input logic [1:0] p2);
    chk({name, "_held"}, 8'(held), 8'(h));
    chk({name, "_p1"}, 8'(p1_dir), 8'(p1));
    chk({name, "_p2"}, 8'(p2_dir), 8'(p2));
    chk({name, "_model"}, 8'(m_held), 8'(h));
  endtask

  initial begin
    step();
    step();
    lit("reset", 4'b0000, 2'b00, 2'b00);
    chk("reset_move", 8'(move_stb), 8'h00);
    resetn = 1'b1;
    step();

    send(8'h1D, 1'b0);             lit("w_make", 4'b0001, 2'b01, 2'b00);
    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);             lit("w_break", 4'b0000, 2'b00, 2'b00);

    send(8'h1D, 1'b0);
    send(8'h1B, 1'b0);             lit("ws_both", 4'b0011, 2'b00, 2'b00);
    send(8'h1D, 1'b0);             lit("typematic", 4'b0011, 2'b00, 2'b00);
    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);             lit("s_only", 4'b0010, 2'b10, 2'b00);
    send(8'hF0, 1'b0);
    send(8'h1B, 1'b0);

    send(8'h44, 1'b0);             lit("o_make", 4'b0100, 2'b00, 2'b01);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h42, 1'b0);             lit("ext_brk", 4'b0100, 2'b00, 2'b01);
    send(8'hE0, 1'b0);
    send(8'h44, 1'b0);             lit("ext_make", 4'b0100, 2'b00, 2'b01);
    send(8'hF0, 1'b0);
    send(8'h44, 1'b0);

    send(8'h42, 1'b0);             lit("k_make", 4'b1000, 2'b00, 2'b10);
    send(8'hF0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) tick();
    lit("tick119", 4'b1000, 2'b00, 2'b10);
    tick();
    lit("tick120", 4'b0000, 2'b00, 2'b00);
    send(8'h1D, 1'b0);             lit("after_tmo", 4'b0001, 2'b01, 2'b00);

    send(8'hF0, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    send(8'h1D, 1'b0);             lit("rst_abort", 4'b0001, 2'b01, 2'b00);

    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);
    tick();
    tick();
    chk("cnt_two", 8'(dut.cnt), 8'd2);
    send(8'h1D, 1'b1);
    lit("kv_tick", 4'b0001, 2'b01, 2'b00);
    chk("kv_tick_cnt", 8'(dut.cnt), 8'd0);
    chk("kv_tick_move", 8'(move_stb), 8'h01);
    step();
    chk("move_one", 8'(move_stb), 8'h00);

    for (int i = 0; i < 4000; i++) begin
      logic quiet;
      quiet = (i >= 1500 && i < 1900);
      key_valid = !quiet && ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0: key_data = 8'h1D;
        1: key_data = 8'h1B;
        2: key_data = 8'h44;
        3: key_data = 8'h42;
        4: key_data = 8'hF0;
        5: key_data = 8'hE0;
        default: key_data = 8'($urandom_range(255));
      endcase
      frame_tick = quiet ? ($urandom_range(1) == 0) : ($urandom_range(2) == 0);
      resetn = !($urandom_range(499) == 0);
      step();
    end
    resetn = 1'b1; key_valid = 1'b0; frame_tick = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
